des_result_fifo: RTL and testbench

Capture buffer directly downstream of the 16-stage pipelined DES core. Every cycle the core's output-valid strobe is high, the block stores the 64-bit ciphertext. It returns stored results to the 32-bit host side as two words per result, high word first, over a valid/ready handshake. The core has no backpressure, so an optional credit counter tracks blocks in flight and tells the issuing logic when issuing another block is safe.

---
 rtl/des_result_fifo.sv | 92 +++++++++
 tb/tb_des_result_fifo.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/des_result_fifo.sv
// des_result_fifo: 64-bit DES result capture FIFO, read out as two 32-bit words (high first).
// Define DES_INFLIGHT_CREDIT_EN to add the in-flight credit counter that drives o_can_issue.
module des_result_fifo #(
    parameter int DEPTH   = 8,
    parameter int LATENCY = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_dv,
    input  logic [63:0]              i_ciphertext,
    input  logic                     i_issue,
    output logic                     o_can_issue,
    output logic [31:0]              o_rdata,
    output logic                     o_rvalid,
    input  logic                     i_rready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    input  logic                     i_clr_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [63:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          hsel_q, hsel_d, ovf_q, ovf_d;
    logic          empty, full, xfer, pop, push;

    always_comb begin
        empty    = count_q == '0;
        full     = count_q == FULL_C;
        xfer     = !empty && i_rready;
        pop      = xfer && hsel_q;
        push     = i_dv && (!full || pop);
        mem_d    = mem_q;
        if (push) mem_d[wr_ptr_q] = i_ciphertext;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        hsel_d   = xfer ? !hsel_q : hsel_q;
        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d    = (i_dv && full && !pop) ? 1'b1 : (i_clr_overflow ? 1'b0 : ovf_q);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hsel_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hsel_q   <= hsel_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o_rvalid   = !empty;
    assign o_rdata    = empty ? 32'h0 : (hsel_q ? mem_q[rd_ptr_q][31:0] : mem_q[rd_ptr_q][63:32]);
    assign o_count    = count_q;
    assign o_overflow = ovf_q;

`ifdef DES_INFLIGHT_CREDIT_EN
    localparam int IW = $clog2(LATENCY + 1) + 1;
    logic [IW-1:0] inflight_q, inflight_d;

    always_comb begin
        inflight_d = inflight_q;
        if (i_issue && !i_dv) inflight_d = inflight_q + IW'(1);
        if (i_dv && !i_issue) inflight_d = inflight_q - IW'(1);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) inflight_q <= '0;
        else       inflight_q <= inflight_d;
    end

    // Registered state only: a pop this cycle does not free a credit until next cycle.
    assign o_can_issue = (int'(count_q) + int'(inflight_q)) < DEPTH;
`else
    logic unused_issue;
    assign unused_issue = i_issue;
    assign o_can_issue  = 1'b1;
`endif
endmodule

// File: tb/tb_des_result_fifo.sv
// tb_des_result_fifo: directed plus random checks of des_result_fifo against a queue-based model.
module tb_des_result_fifo;
    localparam int DEPTH = 8;

    logic        i_clk = 1'b0, i_rst = 1'b1, i_dv = 1'b0, i_issue = 1'b0;
    logic        i_rready = 1'b0, i_clr_overflow = 1'b0;
    logic [63:0] i_ciphertext = '0;
    logic        o_can_issue, o_rvalid, o_overflow;
    logic [31:0] o_rdata;
    logic [3:0]  o_count;

    int          vectors = 0, miscompares = 0;
    logic [63:0] q[$];
    bit          hsel, ovf;
    int          infl;

    des_result_fifo #(.DEPTH(DEPTH), .LATENCY(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_dv(i_dv), .i_ciphertext(i_ciphertext),
        .i_issue(i_issue), .o_can_issue(o_can_issue), .o_rdata(o_rdata),
        .o_rvalid(o_rvalid), .i_rready(i_rready), .o_count(o_count),
        .o_overflow(o_overflow), .i_clr_overflow(i_clr_overflow)
    );

    always #5 i_clk = !i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [63:0] h;
        bit          ci;
        h = (q.size() != 0) ? q[0] : 64'h0;
`ifdef DES_INFLIGHT_CREDIT_EN
        ci = (q.size() + infl) < DEPTH;
`else
        ci = 1'b1;
`endif
        check("rvalid", 64'(o_rvalid), 64'(q.size() != 0));
        check("rdata", 64'(o_rdata), (q.size() == 0) ? 64'h0 : (hsel ? 64'(h[31:0]) : 64'(h[63:32])));
        check("count", 64'(o_count), 64'(q.size()));
        check("overflow", 64'(o_overflow), 64'(ovf));
        check("can_issue", 64'(o_can_issue), 64'(ci));
    endtask

    task automatic step(input bit dv, input logic [63:0] d, input bit rr, input bit clr, input bit iss);
        bit pop, full;
        check_outputs();
        i_dv = dv; i_ciphertext = d; i_rready = rr; i_clr_overflow = clr; i_issue = iss;
        @(posedge i_clk);
        pop  = q.size() > 0 && rr && hsel;
        full = q.size() == DEPTH;
        if (q.size() > 0 && rr) begin
            if (hsel) void'(q.pop_front());
            hsel = !hsel;
        end
        if (dv) begin
            if (!full || pop) q.push_back(d);
            else ovf = 1'b1;
        end
        if (clr && !(dv && full && !pop)) ovf = 1'b0;
        infl += int'(iss) - int'(dv);
        @(negedge i_clk);
        i_dv = 1'b0; i_rready = 1'b0; i_clr_overflow = 1'b0; i_issue = 1'b0;
    endtask

    // Issue accompanies every capture so the credit count stays balanced outside the credit test.
    task automatic cyc(input bit dv, input logic [63:0] d, input bit rr, input bit clr);
        step(dv, d, rr, clr, dv);
    endtask

    task automatic do_reset();
        #2 i_rst = 1'b1;
        #1;
        check("rst_rvalid", 64'(o_rvalid), 64'h0);
        check("rst_count", 64'(o_count), 64'h0);
        check("rst_overflow", 64'(o_overflow), 64'h0);
        check("rst_rdata", 64'(o_rdata), 64'h0);
        q.delete(); hsel = 1'b0; ovf = 1'b0; infl = 0;
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    initial begin
        q.delete(); hsel = 1'b0; ovf = 1'b0; infl = 0;
        #12;
        check_outputs();
        @(negedge i_clk);
        i_rst = 1'b0;

        cyc(1'b1, 64'h85E813540F0AB405, 1'b1, 1'b0);
        check("single_hi", 64'(o_rdata), 64'h85E81354);
        cyc(1'b0, 64'h0, 1'b1, 1'b0);
        check("single_lo", 64'(o_rdata), 64'h0F0AB405);
        cyc(1'b0, 64'h0, 1'b1, 1'b0);
        check("single_empty", 64'(o_rvalid), 64'h0);

        cyc(1'b1, 64'h85E813540F0AB405, 1'b0, 1'b0);
        cyc(1'b0, 64'h0, 1'b1, 1'b0);
        repeat (5) cyc(1'b0, 64'h0, 1'b0, 1'b0);
        check("stall_lo", 64'(o_rdata), 64'h0F0AB405);
        check("stall_count", 64'(o_count), 64'h1);
        cyc(1'b0, 64'h0, 1'b1, 1'b0);
        check("stall_pop", 64'(o_count), 64'h0);

        for (int i = 1; i <= 9; i++) cyc(1'b1, 64'(i), 1'b0, 1'b0);
        check("fill_count", 64'(o_count), 64'h8);
        check("fill_ovf", 64'(o_overflow), 64'h1);
        repeat (16) cyc(1'b0, 64'h0, 1'b1, 1'b0);
        check("drain_count", 64'(o_count), 64'h0);
        cyc(1'b0, 64'h0, 1'b0, 1'b1);
        check("clr_ovf", 64'(o_overflow), 64'h0);

        for (int i = 1; i <= 8; i++) cyc(1'b1, 64'h100 + 64'(i), 1'b0, 1'b0);
        cyc(1'b0, 64'h0, 1'b1, 1'b0);
        cyc(1'b1, 64'hABCD, 1'b1, 1'b0);
        check("pushpop_count", 64'(o_count), 64'h8);
        check("pushpop_ovf", 64'(o_overflow), 64'h0);
        repeat (16) cyc(1'b0, 64'h0, 1'b1, 1'b0);

        do_reset();
        repeat (8) step(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
`ifdef DES_INFLIGHT_CREDIT_EN
        check("credit_block", 64'(o_can_issue), 64'h0);
`else
        check("credit_block", 64'(o_can_issue), 64'h1);
`endif
        step(1'b1, 64'h1122334455667788, 1'b0, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        check("credit_release", 64'(o_can_issue), 64'h1);

        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 64'hDEAD000000000000 + 64'(i), 1'b0, 1'b0);
        cyc(1'b0, 64'h0, 1'b1, 1'b0);
        do_reset();
        cyc(1'b1, 64'hCAFEF00D12345678, 1'b0, 1'b0);
        check("post_rst_hi", 64'(o_rdata), 64'hCAFEF00D);

        for (int i = 0; i < 3000; i++) begin
            bit rr;
            rr = (i < 1500) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
            cyc(1'($urandom % 2), {$urandom, $urandom}, rr, 1'($urandom % 16 == 0));
        end
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
